sr_pulse_gen: RTL and testbench
===============================

SR_PULSE_GEN -- requirements
Module: sr_pulse_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameters SHALL be, one per line: name, default, meaning:
- DEB_CYCLES, 4, consecutive stable cycles required to accept a button level change (1..255).
- PULSE_CYCLES, 3, low-time of each S or R pulse in cycles (1..15).
- GAP_CYCLES, 2, minimum idle cycles between consecutive pulses (0..15).
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, input, 1, rising-edge system clock.
- rst_n, input, 1, asynchronous active-low reset.
- set_btn, input, 1, raw asynchronous set pushbutton, active-high.
- reset_btn, input, 1, raw asynchronous reset pushbutton, active-high.
- S, output, 1, active-low set command to the downstream NAND SR latch.
- R, output, 1, active-low reset command to the downstream NAND SR latch.
- busy, output, 1, high while a pulse or gap is in progress.
- conflict, output, 1, one-cycle pulse when simultaneous set/reset requests are discarded.
REQ-004 All outputs SHALL be registered; S and R SHALL be glitch-free.

Function
REQ-005 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-006 Each synchronized button SHALL be debounced independently: the debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle clears the count.
REQ-007 A 0->1 transition of a debounced button SHALL set that channel's one-deep pending flag; releases SHALL generate nothing.
REQ-008 The FSM SHALL have states IDLE, SET_P, RST_P and GAP.
REQ-009 In IDLE with only set pending, the FSM SHALL go to SET_P, clear set pending and drive S=0 for exactly PULSE_CYCLES cycles.
REQ-010 In IDLE with only reset pending, the FSM SHALL go to RST_P, clear reset pending and drive R=0 for exactly PULSE_CYCLES cycles.
REQ-011 In IDLE with both pending, the FSM SHALL clear both flags, issue no pulse, pulse conflict for one cycle and remain in IDLE.
REQ-012 After SET_P or RST_P, the FSM SHALL enter GAP for GAP_CYCLES cycles (or go directly to IDLE when GAP_CYCLES=0), holding S=R=1.
REQ-013 Requests arriving during SET_P, RST_P or GAP SHALL be held pending and served from IDLE per REQ-009 to REQ-011.
REQ-014 A repeat request on an already-pending channel SHALL be absorbed (no queue depth beyond one).
REQ-015 S=0 and R=0 SHALL never be asserted in the same cycle under any input sequence.
REQ-016 busy SHALL be 1 exactly when the state is SET_P, RST_P or GAP.
REQ-017 Latency SHALL be fixed: S (or R) falls on the (DEB_CYCLES+4)th rising edge after the first edge that samples the button high, given a clean press and an idle FSM.

Reset
REQ-018 While rst_n=0, the block SHALL immediately force S=1, R=1, busy=0 and conflict=0, and clear synchronizers, debounced levels, counters and pending flags, with state IDLE.
REQ-019 Reset asserted mid-pulse SHALL terminate the pulse asynchronously with no partial pulse resumed afterwards.
REQ-020 A button held high through reset release SHALL be treated as a new press once debounced.

Verification (DEB=4, PULSE=3, GAP=2)
REQ-021 Clean set_btn press held 20 cycles -> S low for exactly 3 cycles at edge 8; R stays 1; busy high for 5 cycles.
REQ-022 set_btn glitch of 3 cycles high -> no pulse; glitch of 4+ stable cycles -> exactly one pulse.
REQ-023 set_btn and reset_btn pressed on the same cycle -> conflict pulses once; S and R remain 1.
REQ-024 reset_btn pressed while SET_P is active -> R pulse of 3 cycles begins exactly 2 gap cycles after S returns high; no overlap with S.
REQ-025 rst_n driven low during SET_P cycle 2 -> S=1 immediately; after release, no pulse occurs until a new press.
REQ-026 Random button stimulus for 10k cycles -> assertion S|R never 0 together; every pulse exactly 3 cycles low; gap of at least 2 cycles between pulses.

Source files
------------

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: turns two raw pushbuttons into clean, non-overlapping
// active-low S/R command pulses for a downstream NAND SR latch.
// Path per button: 2-flop synchronizer -> debouncer -> rising-edge
// detector -> one-deep pending flag. A four-state FSM serves the flags.
module sr_pulse_gen #(
  parameter int DEB_CYCLES   = 4,
  parameter int PULSE_CYCLES = 3,
  parameter int GAP_CYCLES   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
);

  typedef enum logic [1:0] {IDLE, SET_P, RST_P, GAP} state_t;

  localparam logic [7:0] DEB_LAST   = 8'(DEB_CYCLES - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST   = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  // Channel 0 is set, channel 1 is reset.
  logic [1:0] w_btn;
  logic [1:0] r_sync1, r_sync2;
  logic [1:0] r_deb, r_deb_d;
  logic [7:0] r_deb_cnt [2];
  logic [1:0] r_pend;
  logic [1:0] w_rise, w_clr;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_clr_s, w_clr_r, w_conflict, w_dispatch;
  logic       r_s, r_r, r_busy, r_conflict;

  assign w_btn  = {reset_btn, set_btn};
  assign w_rise = r_deb & ~r_deb_d;
  assign w_clr  = {w_clr_r, w_clr_s};

  // Two-flop synchronizers for both raw buttons.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncers: level flips after DEB_CYCLES consecutive mismatching cycles.
  // NOTE: the small counter array is reset element by element; unlike a RAM it
  // must start at zero or the first press would debounce in the wrong time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  // One-deep pending flags: a fresh press wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend & ~w_clr) | w_rise;
  end

  // Next-state logic. The end of GAP (or of a pulse when GAP_CYCLES is 0)
  // dispatches exactly like IDLE so the gap between pulses is GAP_CYCLES.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_s     = 1'b0;
    w_clr_r     = 1'b0;
    w_conflict  = 1'b0;
    w_dispatch  = 1'b0;
    case (r_state)
      IDLE: w_dispatch = 1'b1;
      SET_P, RST_P: begin
        if (r_cnt == PULSE_LAST) begin
          if (GAP_CYCLES == 0) begin
            w_dispatch = 1'b1;
          end else begin
            w_state_nxt = GAP;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) w_dispatch = 1'b1;
        else                   w_cnt_nxt  = r_cnt + 4'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_dispatch) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      if (r_pend[0] && r_pend[1]) begin
        w_clr_s    = 1'b1;
        w_clr_r    = 1'b1;
        w_conflict = 1'b1;
      end else if (r_pend[0]) begin
        w_state_nxt = SET_P;
        w_clr_s     = 1'b1;
      end else if (r_pend[1]) begin
        w_state_nxt = RST_P;
        w_clr_r     = 1'b1;
      end
    end
  end

  // State register plus registered outputs decoded from the next state,
  // so S and R come straight from flops and cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_s        <= 1'b1;
      r_r        <= 1'b1;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_s        <= (w_state_nxt != SET_P);
      r_r        <= (w_state_nxt != RST_P);
      r_busy     <= (w_state_nxt != IDLE);
      r_conflict <= w_conflict;
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign busy     = r_busy;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Bench for sr_pulse_gen (DEB=4, PULSE=3, GAP=2). Expected pulses are
// pushed to q_exp when a button is driven; a negedge monitor records the
// observed S/R pulses into q_obs, and each test pops and compares both.
module tb_sr_pulse_gen;

  typedef struct {
    bit kind;   // 0 = S pulse, 1 = R pulse
    int start;  // cycle index of the edge that made the output low
    int len;    // low cycles
  } pulse_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_btn = 1'b0;
  logic reset_btn = 1'b0;
  logic S, R, busy, conflict;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  pulse_t q_exp[$];
  pulse_t q_obs[$];

  bit s_prev = 1'b1, r_prev = 1'b1;
  int s_start = 0, r_start = 0;

  sr_pulse_gen #(.DEB_CYCLES(4), .PULSE_CYCLES(3), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .reset_btn(reset_btn),
    .S(S), .R(R), .busy(busy), .conflict(conflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required finish before", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: records pulses and checks S/R exclusivity and busy coverage.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (S === 1'b0 && R === 1'b0) begin
        n_err++;
        $display("FAIL overlap: S=%b R=%b at cycle %0d, required never both 0", S, R, cyc);
      end
      if ((S === 1'b0 || R === 1'b0) && busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_during_pulse: busy=%b at cycle %0d, required 1", busy, cyc);
      end
    end
    if (S === 1'b0 && s_prev) s_start = cyc;
    if (S === 1'b1 && !s_prev) q_obs.push_back('{1'b0, s_start, cyc - s_start});
    if (R === 1'b0 && r_prev) r_start = cyc;
    if (R === 1'b1 && !r_prev) q_obs.push_back('{1'b1, r_start, cyc - r_start});
    s_prev = (S !== 1'b0);
    r_prev = (R !== 1'b0);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    set_btn = 1'b1; reset_btn = 1'b1; rst_n = 1'b0;
    step(3);
    n_cmp++; if (S !== 1'b1)        begin n_err++; $display("FAIL reset_S: got %b, required 1", S); end
    n_cmp++; if (R !== 1'b1)        begin n_err++; $display("FAIL reset_R: got %b, required 1", R); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (conflict !== 1'b0) begin n_err++; $display("FAIL reset_conflict: got %b, required 0", conflict); end
    set_btn = 1'b0; reset_btn = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(10);
  endtask

  task automatic test_clean_press();
    int k, nbusy, nrlow;
    q_obs.delete(); q_exp.delete();
    k = cyc; set_btn = 1'b1;
    q_exp.push_back('{1'b0, k + 8, 3});
    nbusy = 0; nrlow = 0;
    repeat (20) begin
      step(1);
      if (busy === 1'b1) nbusy++;
      if (R !== 1'b1) nrlow++;
    end
    set_btn = 1'b0;
    step(20);
    n_cmp++; if (nbusy !== 5) begin n_err++; $display("FAIL clean_busy_cycles: got %0d, required 5", nbusy); end
    n_cmp++; if (nrlow !== 0) begin n_err++; $display("FAIL clean_R_low: got %0d cycles, required 0", nrlow); end
    n_cmp++;
    if (q_obs.size() !== q_exp.size()) begin
      n_err++; $display("FAIL clean_count: got %0d pulses, required %0d", q_obs.size(), q_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      pulse_t o, e;
      o = q_obs.pop_front(); e = q_exp.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL clean_pulse: got kind=%0d start=%0d len=%0d, required kind=%0d start=%0d len=%0d",
                 o.kind, o.start, o.len, e.kind, e.start, e.len);
      end
    end
  endtask

  task automatic test_glitch();
    int k;
    q_obs.delete(); q_exp.delete();
    set_btn = 1'b1; step(3); set_btn = 1'b0;
    step(25);
    n_cmp++; if (q_obs.size() !== 0) begin n_err++; $display("FAIL glitch3: got %0d pulses, required 0", q_obs.size()); end
    q_obs.delete();
    k = cyc; set_btn = 1'b1;
    q_exp.push_back('{1'b0, k + 8, 3});
    step(4); set_btn = 1'b0;
    step(25);
    n_cmp++;
    if (q_obs.size() !== q_exp.size()) begin
      n_err++; $display("FAIL glitch4_count: got %0d pulses, required %0d", q_obs.size(), q_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      pulse_t o, e;
      o = q_obs.pop_front(); e = q_exp.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL glitch4_pulse: got kind=%0d start=%0d len=%0d, required kind=%0d start=%0d len=%0d",
                 o.kind, o.start, o.len, e.kind, e.start, e.len);
      end
    end
  endtask

  task automatic test_conflict();
    int k, nconf, conf_at;
    q_obs.delete(); q_exp.delete();
    k = cyc; set_btn = 1'b1; reset_btn = 1'b1;
    nconf = 0; conf_at = -1;
    repeat (20) begin
      step(1);
      if (conflict === 1'b1) begin nconf++; conf_at = cyc; end
    end
    set_btn = 1'b0; reset_btn = 1'b0;
    step(20);
    n_cmp++; if (nconf !== 1)      begin n_err++; $display("FAIL conflict_count: got %0d, required 1", nconf); end
    n_cmp++; if (conf_at !== k + 8) begin n_err++; $display("FAIL conflict_cycle: got %0d, required %0d", conf_at, k + 8); end
    n_cmp++; if (q_obs.size() !== 0) begin n_err++; $display("FAIL conflict_pulses: got %0d, required 0", q_obs.size()); end
  endtask

  task automatic test_back_to_back();
    int k;
    q_obs.delete(); q_exp.delete();
    k = cyc; set_btn = 1'b1;
    q_exp.push_back('{1'b0, k + 8, 3});
    step(2); reset_btn = 1'b1;
    q_exp.push_back('{1'b1, k + 13, 3});
    step(20);
    set_btn = 1'b0; reset_btn = 1'b0;
    step(20);
    n_cmp++;
    if (q_obs.size() !== q_exp.size()) begin
      n_err++; $display("FAIL b2b_count: got %0d pulses, required %0d", q_obs.size(), q_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      pulse_t o, e;
      o = q_obs.pop_front(); e = q_exp.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL b2b_pulse: got kind=%0d start=%0d len=%0d, required kind=%0d start=%0d len=%0d",
                 o.kind, o.start, o.len, e.kind, e.start, e.len);
      end
    end
  endtask

  task automatic test_rst_mid_pulse();
    int k;
    q_obs.delete(); q_exp.delete();
    k = cyc; set_btn = 1'b1;
    q_exp.push_back('{1'b0, k + 8, 2});
    step(9);
    #2 rst_n = 1'b0; set_btn = 1'b0;
    #1;
    n_cmp++; if (S !== 1'b1)    begin n_err++; $display("FAIL midrst_S: got %b, required 1", S); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    step(3);
    rst_n = 1'b1;
    step(30);
    n_cmp++;
    if (q_obs.size() !== q_exp.size()) begin
      n_err++; $display("FAIL midrst_count: got %0d pulses, required %0d", q_obs.size(), q_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      pulse_t o, e;
      o = q_obs.pop_front(); e = q_exp.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL midrst_pulse: got kind=%0d start=%0d len=%0d, required kind=%0d start=%0d len=%0d",
                 o.kind, o.start, o.len, e.kind, e.start, e.len);
      end
    end
  endtask

  task automatic test_held_through_reset();
    int c;
    q_obs.delete(); q_exp.delete();
    rst_n = 1'b0; reset_btn = 1'b1;
    step(3);
    rst_n = 1'b1; c = cyc;
    q_exp.push_back('{1'b1, c + 8, 3});
    step(20);
    reset_btn = 1'b0;
    step(20);
    n_cmp++;
    if (q_obs.size() !== q_exp.size()) begin
      n_err++; $display("FAIL held_count: got %0d pulses, required %0d", q_obs.size(), q_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      pulse_t o, e;
      o = q_obs.pop_front(); e = q_exp.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL held_pulse: got kind=%0d start=%0d len=%0d, required kind=%0d start=%0d len=%0d",
                 o.kind, o.start, o.len, e.kind, e.start, e.len);
      end
    end
  endtask

  task automatic test_random();
    int prev_end, npulse;
    q_obs.delete(); q_exp.delete();
    repeat (10000) begin
      if ($urandom_range(5) == 0) set_btn = ~set_btn;
      if ($urandom_range(5) == 0) reset_btn = ~reset_btn;
      step(1);
    end
    set_btn = 1'b0; reset_btn = 1'b0;
    step(40);
    prev_end = -100; npulse = 0;
    while (q_obs.size() > 0) begin
      pulse_t o;
      o = q_obs.pop_front();
      npulse++;
      n_cmp++;
      if (o.len !== 3) begin
        n_err++; $display("FAIL rand_len: got %0d at cycle %0d, required 3", o.len, o.start);
      end
      n_cmp++;
      if (o.start - prev_end < 2) begin
        n_err++; $display("FAIL rand_gap: got %0d at cycle %0d, required >= 2", o.start - prev_end, o.start);
      end
      prev_end = o.start + o.len;
    end
    n_cmp++;
    if (npulse < 10) begin n_err++; $display("FAIL rand_activity: got %0d pulses, required >= 10", npulse); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_conflict();
    test_back_to_back();
    test_rst_mid_pulse();
    test_held_through_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
